// File: rtl/dmem_responder.sv
// Data-memory target for the core's load/store port: valid/ready request and
// response channels with LATENCY wait states and one outstanding transaction.
module dmem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_M1 = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept;
  logic        commit;

  logic        wr_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;

  logic        c_write;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_err;
  logic [IW-1:0] c_idx;
  logic [31:0] rd_word;

  // Power-up contents are mem[i] = i: words never stored read back their own
  // index, so only the written mask needs an initial value.
  logic [31:0]      mem [DEPTH];
  logic [DEPTH-1:0] written = '0;

  logic [31:0] rdata_p1;
  logic        err_p1;

  assign accept    = (state == IDLE) && req_valid && rst;
  assign req_ready = (state == IDLE) && rst;
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_p1;
  assign rsp_err   = err_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p0: request captured at acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_p0    <= req_write;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
    end
  end

  // A zero-latency commit happens on the accept edge, straight from the inputs.
  assign c_write = (state == IDLE) ? req_write : wr_p0;
  assign c_addr  = (state == IDLE) ? req_addr  : addr_p0;
  assign c_wdata = (state == IDLE) ? req_wdata : wdata_p0;
  assign c_idx   = c_addr[IW+1:2];
  assign c_err   = (c_addr[1:0] != 2'b00) || (c_addr[31:2] >= 30'(DEPTH));
  assign rd_word = written[c_idx] ? mem[c_idx] : 32'(c_idx);

  always_ff @(posedge clk) begin
    if (commit && c_write && !c_err) begin
      mem[c_idx]     <= c_wdata;
      written[c_idx] <= 1'b1;
    end
  end

  // p1: response registers, held until the handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_p1 <= 32'd0;
      err_p1   <= 1'b0;
    end else if (commit) begin
      rdata_p1 <= (c_write || c_err) ? 32'd0 : rd_word;
      err_p1   <= c_err;
    end else if (state == RESP && rsp_ready) begin
      rdata_p1 <= 32'd0;
      err_p1   <= 1'b0;
    end
  end

endmodule
